// File: rtl/turbo_pingpong_outbuf_if.sv
// Symbol stream interface of the turbo encoder ping-pong output buffer.
// The master drives the encoder-side inputs and consumer ready; the slave is the buffer.
interface turbo_pingpong_outbuf_if #(
    parameter int unsigned CH = 3
) ();
    logic          len_sel;
    logic          in_valid;
    logic          in_tail;
    logic [CH-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [CH-1:0] out_data;
    logic          out_tail;
    logic          out_last;
    logic          out_bank;
    logic [1:0]    bank_full;
    logic          overflow;
    logic          frame_err;

    modport master (
        output len_sel, in_valid, in_tail, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_tail, out_last, out_bank,
        input  bank_full, overflow, frame_err
    );

    modport slave (
        input  len_sel, in_valid, in_tail, in_data, out_ready,
        output in_ready, out_valid, out_data, out_tail, out_last, out_bank,
        output bank_full, overflow, frame_err
    );
endinterface

// File: rtl/turbo_pingpong_outbuf.sv
// Two-bank ping-pong buffer: one bank fills with a code block (data then tail) while
// the other replays its stored block on a ready/valid stream with framing flags.
module turbo_pingpong_outbuf #(
    parameter int unsigned CH        = 3,
    parameter int unsigned LEN_SHORT = 6,
    parameter int unsigned LEN_LONG  = 40,
    parameter int unsigned TAIL      = 4,
    parameter int unsigned PW        = 16
) (
    input logic                   clk,
    input logic                   rst,
    turbo_pingpong_outbuf_if.slave bus
);
    localparam int unsigned DEPTH = LEN_LONG + TAIL;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StReadData, StReadTail} state_e;

    function automatic logic [PW-1:0] k_len(input logic sel);
        return sel ? PW'(LEN_LONG) : PW'(LEN_SHORT);
    endfunction

    function automatic logic [PW-1:0] last_idx(input logic sel);
        return k_len(sel) + PW'(TAIL) - PW'(1);
    endfunction

    logic [CH-1:0] mem [2][DEPTH];

    state_e        state_q, state_d;
    logic          wr_bank_q, rd_bank_q, rd_bank_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [1:0]    bank_full_q, bank_full_d;
    logic [1:0]    klen_q;
    logic          overflow_q, frame_err_q;

    logic wr_sel, wr_acc, wr_last, wr_done, wr_bad;
    logic rd_sel, rd_end, xfer, rd_done, out_valid, out_tail;

    // The first symbol of a block defines K before klen is latched.
    assign wr_sel  = (wr_ptr_q == '0) ? bus.len_sel : klen_q[wr_bank_q];
    assign wr_acc  = bus.in_valid & ~bank_full_q[wr_bank_q];
    assign wr_last = (wr_ptr_q == last_idx(wr_sel));
    assign wr_done = wr_acc & wr_last;
    assign wr_bad  = bus.in_tail != (wr_ptr_q >= k_len(wr_sel));

    assign rd_sel = klen_q[rd_bank_q];
    assign rd_end = (rd_ptr_q == last_idx(rd_sel));
    assign xfer   = out_valid & bus.out_ready;

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_bank_d = rd_bank_q;
        rd_done   = 1'b0;
        out_valid = 1'b0;
        out_tail  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d  = StReadData;
                    rd_ptr_d = '0;
                end
            end
            StReadData: begin
                out_valid = 1'b1;
                if (xfer) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    if (rd_ptr_q == k_len(rd_sel) - PW'(1)) state_d = StReadTail;
                end
            end
            StReadTail: begin
                out_valid = 1'b1;
                out_tail  = 1'b1;
                if (xfer) begin
                    if (rd_end) begin
                        rd_done   = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        rd_ptr_d  = '0;
                        // Back-to-back replay when the other bank is already waiting.
                        state_d   = bank_full_q[~rd_bank_q] ? StReadData : StIdle;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bank_full_d = bank_full_q;
        if (rd_done) bank_full_d[rd_bank_q] = 1'b0;
        if (wr_done) bank_full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            bank_full_q <= 2'b00;
            klen_q      <= 2'b00;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            rd_ptr_q    <= rd_ptr_d;
            bank_full_q <= bank_full_d;
            if (bus.in_valid & bank_full_q[wr_bank_q]) overflow_q <= 1'b1;
            if (wr_acc) begin
                if (wr_bad) frame_err_q <= 1'b1;
                if (wr_ptr_q == '0) klen_q[wr_bank_q] <= bus.len_sel;
                if (wr_last) begin
                    wr_bank_q <= ~wr_bank_q;
                    wr_ptr_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_bank_q][wr_ptr_q[AW-1:0]] <= bus.in_data;
    end

    assign bus.in_ready  = ~bank_full_q[wr_bank_q];
    assign bus.out_valid = out_valid;
    assign bus.out_tail  = out_tail;
    assign bus.out_data  = mem[rd_bank_q][rd_ptr_q[AW-1:0]];
    assign bus.out_last  = (state_q == StReadTail) & rd_end;
    assign bus.out_bank  = rd_bank_q;
    assign bus.bank_full = bank_full_q;
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_turbo_pingpong_outbuf.sv
// Bench for turbo_pingpong_outbuf: block-level scoreboard model, a table of single-block
// scenarios, hand-written multi-block sequences and a randomized run.
module tb_turbo_pingpong_outbuf;
    localparam int unsigned CH = 3, LS = 6, LL = 40, TL = 4, PW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turbo_pingpong_outbuf_if #(.CH(CH)) bus ();

    turbo_pingpong_outbuf #(
        .CH(CH), .LEN_SHORT(LS), .LEN_LONG(LL), .TAIL(TL), .PW(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [CH-1:0] data;
        bit            tail;
        bit            last;
        bit            bank;
    } sym_t;

    typedef struct {
        bit len;
        int bad;
        bit toggle;
        int exp_len;
        bit exp_fe;
    } vec_t;

    // Model: queue of accepted symbols in output order plus block counters.
    sym_t q[$];
    int   wcnt, rcnt, wptr, cur_k;
    bit   m_ovf, m_fe;
    int   nvec, nerr, xfers, cyc;
    int   last_at[$];
    int   xcyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int klen(input bit sel);
        return sel ? LL : LS;
    endfunction

    function automatic logic [1:0] exp_full();
        int n;
        n = wcnt - rcnt;
        if (n == 0) return 2'b00;
        if (n == 1) return (rcnt % 2 == 1) ? 2'b10 : 2'b01;
        return 2'b11;
    endfunction

    task automatic model_reset();
        q.delete();
        wcnt = 0; rcnt = 0; wptr = 0; cur_k = LS;
        m_ovf = 1'b0; m_fe = 1'b0;
    endtask

    // One clock: check outputs before the edge, update model for that edge, return at negedge.
    task automatic tick();
        bit   acc, tp;
        int   k;
        sym_t s;
        #1;
        chk("in_ready", bus.in_ready, (wcnt - rcnt) < 2);
        chk("bank_full", bus.bank_full, exp_full());
        chk("overflow", bus.overflow, m_ovf);
        chk("frame_err", bus.frame_err, m_fe);
        if (wcnt == rcnt) chk("valid_no_block", bus.out_valid, 0);
        acc = bus.in_valid && ((wcnt - rcnt) < 2);
        if (!rst) begin
            if (bus.in_valid && !acc) m_ovf = 1'b1;
            if (acc) begin
                if (wptr == 0) cur_k = klen(bus.len_sel);
                k  = cur_k;
                tp = (wptr >= k);
                if (bus.in_tail != tp) m_fe = 1'b1;
                q.push_back('{bus.in_data, tp, wptr == k + TL - 1, wcnt % 2 == 1});
                if (wptr == k + TL - 1) begin
                    wptr = 0;
                    wcnt++;
                end else begin
                    wptr++;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                xfers++;
                xcyc.push_back(cyc);
                if (bus.out_last) last_at.push_back(xfers);
                if (q.size() == 0) begin
                    chk("xfer_unexpected", bus.out_valid, 0);
                end else begin
                    s = q.pop_front();
                    chk("out_data", bus.out_data, s.data);
                    chk("out_tail", bus.out_tail, s.tail);
                    chk("out_last", bus.out_last, s.last);
                    chk("out_bank", bus.out_bank, s.bank);
                    if (s.last) rcnt++;
                end
            end
        end
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        @(negedge clk);
    endtask

    task automatic put(input bit len, input logic [CH-1:0] d, input bit t, input bit wait_rdy);
        int n;
        n = 0;
        while (wait_rdy && bus.in_ready !== 1'b1 && n < 200) begin
            bus.in_valid = 1'b0;
            tick();
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", bus.in_ready, 1);
        bus.len_sel  = len;
        bus.in_valid = 1'b1;
        bus.in_tail  = t;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic write_block(input bit len, input int bad);
        int k;
        k = klen(len);
        for (int i = 0; i < k + TL; i++) put(len, CH'(i + 1), (i >= k) ^ (i == bad), 1'b1);
    endtask

    task automatic drain(input bit toggle, input int maxc);
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((q.size() != 0 || bus.out_valid === 1'b1) && n < maxc) begin
            if (toggle) bus.out_ready = ~bus.out_ready;
            tick();
            n++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_tail = 1'b0; bus.in_data = '0;
        bus.len_sel = 1'b0;  bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        xfers = 0;
        last_at.delete();
        xcyc.delete();
    endtask

    vec_t tbl[5];

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec = 0; nerr = 0; cyc = 0;
        tbl[0] = '{1'b0, -1, 1'b0, 10, 1'b0};
        tbl[1] = '{1'b1, -1, 1'b0, 44, 1'b0};
        tbl[2] = '{1'b0, -1, 1'b1, 10, 1'b0};
        tbl[3] = '{1'b1,  5, 1'b0, 44, 1'b1};
        tbl[4] = '{1'b0,  3, 1'b1, 10, 1'b1};

        hard_reset();
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_bank_full", bus.bank_full, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_out_bank", bus.out_bank, 0);

        // Single-block scenarios.
        for (int v = 0; v < 5; v++) begin
            hard_reset();
            bus.out_ready = !tbl[v].toggle;
            write_block(tbl[v].len, tbl[v].bad);
            if (!tbl[v].toggle) begin
                #1 chk("latency_e0", bus.out_valid, 0);
                tick();
                #1 chk("latency_e1", bus.out_valid, 1);
            end
            drain(tbl[v].toggle, 200);
            chk("xfer_count", xfers, tbl[v].exp_len);
            chk("last_count", last_at.size(), 1);
            if (last_at.size() > 0) chk("last_pos", last_at[0], tbl[v].exp_len);
            chk("block_frame_err", bus.frame_err, tbl[v].exp_fe);
            chk("block_bank_full", bus.bank_full, 0);
            if (tbl[v].toggle && xcyc.size() == tbl[v].exp_len)
                chk("stall_span", xcyc[xcyc.size() - 1] - xcyc[0], 2 * tbl[v].exp_len - 2);
        end

        // Three long blocks streamed; blocks 1 and 2 leave back to back.
        hard_reset();
        bus.out_ready = 1'b1;
        repeat (3) write_block(1'b1, -1);
        drain(1'b0, 300);
        chk("pp_xfers", xfers, 132);
        if (xcyc.size() == 132) chk("pp_no_gap", xcyc[87] - xcyc[0], 87);
        chk("pp_overflow", bus.overflow, 0);

        // Overflow: both banks full, 21st symbol dropped.
        hard_reset();
        write_block(1'b0, -1);
        write_block(1'b0, -1);
        put(1'b0, 3'd5, 1'b0, 1'b0);
        #1;
        chk("ovf_bank_full", bus.bank_full, 2'b11);
        chk("ovf_in_ready", bus.in_ready, 0);
        chk("ovf_flag", bus.overflow, 1);
        drain(1'b0, 100);
        chk("ovf_xfers", xfers, 20);
        chk("ovf_sticky", bus.overflow, 1);

        // Mixed length with a misplaced tail marker.
        hard_reset();
        bus.out_ready = 1'b1;
        write_block(1'b1, 5);
        write_block(1'b0, -1);
        drain(1'b0, 200);
        chk("mix_nlast", last_at.size(), 2);
        if (last_at.size() == 2) begin
            chk("mix_last0", last_at[0], 44);
            chk("mix_last1", last_at[1], 54);
        end
        chk("mix_frame_err", bus.frame_err, 1);

        // Reset during the third output symbol.
        hard_reset();
        bus.out_ready = 1'b1;
        write_block(1'b0, 2);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_bank_full", bus.bank_full, 0);
        chk("mrst_overflow", bus.overflow, 0);
        chk("mrst_frame_err", bus.frame_err, 0);
        write_block(1'b0, -1);
        tick();
        #1;
        chk("mrst_valid_new", bus.out_valid, 1);
        chk("mrst_bank_new", bus.out_bank, 0);
        drain(1'b0, 100);

        // Randomized traffic against the model.
        hard_reset();
        for (int c = 0; c < 2500; c++) begin
            bit len;
            int k;
            len = 1'($urandom_range(0, 1));
            k   = (wptr == 0) ? klen(len) : cur_k;
            bus.len_sel   = len;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = CH'($urandom);
            bus.in_tail   = (wptr >= k) ^ ($urandom_range(0, 49) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.in_valid = 1'b0;
        if (wptr != 0) begin
            int rem;
            rem = cur_k + TL - wptr;
            for (int i = 0; i < rem; i++) put(1'b0, CH'($urandom), (wptr >= cur_k), 1'b1);
        end
        drain(1'b0, 300);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
